// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider.
// A packed operand bus {dividend, divisor} is latched on start, then one
// quotient bit is resolved per clock. The packed result {quotient, remainder}
// is published together with a one-cycle done pulse and held until the next
// result or reset.
module restoring_divider_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] in,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done
);

    // Iteration counter is wide enough to index steps 0..WIDTH-1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    // Partial remainder carries one extra bit so the trial subtraction's
    // sign can be read straight from its MSB.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div;
    logic [CW-1:0]    count;

    logic load;
    logic step;
    logic finish;

    logic [WIDTH:0]   acc_shift;
    logic [WIDTH:0]   trial;
    logic             trial_neg;
    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] quo_step;

    // One restoring step: shift {acc,quo} left, trial-subtract the divisor,
    // keep the difference only when it did not go negative.
    always_comb begin
        acc_shift = {acc[WIDTH-1:0], quo[WIDTH-1]};
        trial     = acc_shift - {1'b0, div};
        trial_neg = trial[WIDTH];
        acc_step  = trial_neg ? acc_shift : trial;
        quo_step  = {quo[WIDTH-2:0], ~trial_neg};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: start is only honoured from IDLE, so requests
    // arriving while a division runs are dropped rather than queued.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == LAST_STEP) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers: operands are captured only on load, so the input
    // bus is free to change once the division is under way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            quo   <= '0;
            div   <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            quo   <= in[2*WIDTH-1:WIDTH];
            div   <= in[WIDTH-1:0];
            count <= '0;
        end else if (step) begin
            acc   <= acc_step;
            quo   <= quo_step;
            count <= count + CW'(1);
        end
    end

    // Result and handshake registers: the result is taken from the final
    // step's combinational values so it lands on the same edge as done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                busy <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
            if (finish) begin
                out <= {quo_step, acc_step[WIDTH-1:0]};
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Testbench for restoring_divider_seq: directed vector table, multi-cycle
// corner sequences, random operands and an exhaustive back-to-back sweep,
// all compared against plain-arithmetic expectations.
module tb_restoring_divider_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] in_bus;
    logic [7:0] out_bus;
    logic       busy;
    logic       done;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] expected;
    } vector_t;

    restoring_divider_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_bus),
        .out   (out_bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: quotient/remainder by plain arithmetic; divide by zero
    // yields all-ones quotient and the dividend as remainder.
    function automatic logic [7:0] refDivide(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q;
        logic [3:0] r;
        if (b == 4'd0) begin
            q = 4'hF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Pulse start for one cycle with {a,b}, then wait (bounded) for done.
    // latency is the number of clocks after the accepting edge, -1 on timeout.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 output logic [7:0] result, output int latency);
        @(negedge clk);
        in_bus = {a, b};
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        latency = -1;
        result  = 8'h00;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                latency = i;
                result  = out_bus;
                break;
            end
        end
    endtask

    initial begin
        vector_t    vectors[9];
        logic [7:0] result;
        int         latency;
        int         doneCount;
        int         cnt;
        logic [3:0] ra;
        logic [3:0] rb;

        vectors[0] = '{4'd10, 4'd3, 8'h31};
        vectors[1] = '{4'd15, 4'd5, 8'h30};
        vectors[2] = '{4'd9,  4'd2, 8'h41};
        vectors[3] = '{4'd7,  4'd3, 8'h21};
        vectors[4] = '{4'd8,  4'd4, 8'h20};
        vectors[5] = '{4'd15, 4'd1, 8'hF0};
        vectors[6] = '{4'd2,  4'd7, 8'h02};
        vectors[7] = '{4'd9,  4'd0, 8'hF9};
        vectors[8] = '{4'd0,  4'd0, 8'hF0};

        rst    = 1'b1;
        start  = 1'b0;
        in_bus = 8'h00;
        #12;
        checkOutput("reset_out", 32'(out_bus), 32'h00);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: result and start-to-done latency.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, result, latency);
            checkOutput($sformatf("vec%0d_out", i), 32'(result), 32'(vectors[i].expected));
            checkOutput($sformatf("vec%0d_latency", i), 32'(latency), 32'd4);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done), 32'h0);
        end

        // Result holds between divisions.
        repeat (3) @(negedge clk);
        checkOutput("hold_out", 32'(out_bus), 32'hF0);
        checkOutput("hold_busy", 32'(busy), 32'h0);

        // Start while busy with new operands is ignored.
        @(negedge clk);
        in_bus = {4'd10, 4'd3};
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_asserted", 32'(busy), 32'h1);
        @(negedge clk);
        in_bus = {4'd15, 4'd5};
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 2;
        latency = -1;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                latency = cnt;
                break;
            end
            @(negedge clk);
            cnt++;
        end
        checkOutput("ignore_latency", 32'(latency), 32'd4);
        checkOutput("ignore_out", 32'(out_bus), 32'h31);
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("ignore_no_second_done", 32'(doneCount), 32'd0);

        // Asynchronous reset two cycles into a division aborts it.
        @(negedge clk);
        in_bus = {4'd9, 4'd2};
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_out", 32'(out_bus), 32'h00);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
        checkOutput("abort_out_held", 32'(out_bus), 32'h00);
        applyStimulus(4'd7, 4'd3, result, latency);
        checkOutput("after_abort_out", 32'(result), 32'h21);
        checkOutput("after_abort_latency", 32'(latency), 32'd4);

        // Start held high restarts each time the divider returns to idle.
        @(negedge clk);
        in_bus = {4'd14, 4'd4};
        start  = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 30 && doneCount < 3; i++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                checkOutput($sformatf("held_out%0d", doneCount), 32'(out_bus), 32'h32);
            end
        end
        checkOutput("held_done_count", 32'(doneCount), 32'd3);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("held_idle", 32'(busy), 32'h0);

        // Random operands.
        for (int i = 0; i < 30; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            applyStimulus(ra, rb, result, latency);
            checkOutput($sformatf("rand_%0d_%0d", ra, rb), 32'(result), 32'(refDivide(ra, rb)));
        end

        // Exhaustive sweep, each new start issued in the cycle done is high.
        @(negedge clk);
        @(negedge clk);
        in_bus = 8'h00;
        start  = 1'b1;
        for (int idx = 0; idx < 256; idx++) begin
            logic [7:0] pair;
            pair = 8'(idx);
            @(negedge clk);
            start = 1'b0;
            latency = -1;
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (done) begin
                    latency = i;
                    break;
                end
            end
            checkOutput($sformatf("sweep_%0d_%0d", pair[7:4], pair[3:0]), 32'(out_bus),
                        32'(refDivide(pair[7:4], pair[3:0])));
            if (latency < 0) begin
                checkOutput("sweep_timeout", 32'(latency), 32'd4);
                break;
            end
            if (idx < 255) begin
                in_bus = 8'(idx + 1);
                start  = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
